seg_scan_capture: RTL and testbench

// - Inverse of the BCD-to-7-segment encoder: snoops the multiplexed display bus (active-low segments, active-low anodes)
//   and recovers the BCD digit currently shown on each display position.
// - Sits between the display driver outputs and the self-check/readback logic so that displayed Collatz values can be compared on chip.
// - Qualifies each (anode, segment) pair for stability, decodes it, and publishes one complete frame at a time over a valid/ack handshake.

---
 rtl/seg_scan_capture_pkg.sv | 31 +++
 rtl/seg_scan_capture_seg_to_bcd.sv | 27 ++
 rtl/seg_scan_capture.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_capture_pkg.sv
// Shared segment-pattern constants and decode result type for the display-bus snooper.
// Patterns are active-low gfedcba, identical to what the BCD-to-7-segment encoder drives.
package seg_scan_capture_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] bcd;
    } seg_dec_t;

endpackage

// File: rtl/seg_scan_capture_seg_to_bcd.sv
// Combinational inverse of the 7-segment encoder: pattern -> {err, blank, bcd}.
module seg_to_bcd
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '0;
        case (seg)
            SEG_0:     dec.bcd   = 4'd0;
            SEG_1:     dec.bcd   = 4'd1;
            SEG_2:     dec.bcd   = 4'd2;
            SEG_3:     dec.bcd   = 4'd3;
            SEG_4:     dec.bcd   = 4'd4;
            SEG_5:     dec.bcd   = 4'd5;
            SEG_6:     dec.bcd   = 4'd6;
            SEG_7:     dec.bcd   = 4'd7;
            SEG_8:     dec.bcd   = 4'd8;
            SEG_9:     dec.bcd   = 4'd9;
            SEG_BLANK: dec.blank = 1'b1;
            default:   dec.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Snoops the multiplexed 7-segment bus, qualifies stable digits and publishes whole frames over valid/ack.
// Optional macro SEG_SCAN_ERRCNT_EN adds a saturating err_count output for undecodable digits.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic                    frame_err,
    output logic                    overrun
`ifdef SEG_SCAN_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PAIR_W = NUM_DIGITS + 7;

    logic [6:0]              s_seg_q, s_seg_d;
    logic [NUM_DIGITS-1:0]   s_an_q, s_an_d;
    logic [PAIR_W-1:0]       prev_q, prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    overrun_q, overrun_d;
`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0]              errcnt_q, errcnt_d;
`endif

    logic [NUM_DIGITS-1:0]   lit;
    logic                    lit_one;
    logic [IDX_W-1:0]        lit_idx;
    logic [PAIR_W-1:0]       cur;
    logic                    accept;
    logic                    complete;
    seg_dec_t                dec;

    seg_to_bcd u_dec (
        .seg (s_seg_q),
        .dec (dec)
    );

    always_comb begin
        s_seg_d = seg_in;
        s_an_d  = an_in;
        cur     = {s_an_q, s_seg_q};
        lit     = ~s_an_q;
        lit_one = (lit != '0) && ((lit & (lit - 1'b1)) == '0);
        lit_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lit[i]) lit_idx = IDX_W'(i);
        end
    end

    // Counter saturates at STABLE_CYCLES so a held pair is accepted only on the step into that value.
    always_comb begin
        prev_d = cur;
        if (!lit_one) begin
            cnt_d = '0;
        end else if ((cur == prev_q) && (cnt_q != '0)) begin
            cnt_d = (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        end else begin
            cnt_d = CNT_W'(1);
        end
        accept = lit_one && (cur == prev_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end

    always_comb begin
        complete       = &mask_q;
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        shadow_err_d   = shadow_err_q;
        mask_d         = complete ? '0 : mask_q;
        bcd_d          = bcd_q;
        blank_d        = blank_q;
        err_d          = err_q;
        valid_d        = valid_q;
        overrun_d      = overrun_q;

        if (accept) begin
            shadow_d[{lit_idx, 2'b00} +: 4] = dec.bcd;
            shadow_blank_d[lit_idx]         = dec.blank;
            shadow_err_d[lit_idx]           = dec.err;
            mask_d[lit_idx]                 = 1'b1;
        end

        // A completing frame is dropped rather than overwrite an unacknowledged one.
        if (complete) begin
            if (!valid_q || frame_ack) begin
                bcd_d   = shadow_q;
                blank_d = shadow_blank_q;
                err_d   = |shadow_err_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && frame_ack) begin
            valid_d = 1'b0;
        end
    end

`ifdef SEG_SCAN_ERRCNT_EN
    always_comb begin
        errcnt_d = errcnt_q;
        if (accept && dec.err && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg_q        <= '0;
            s_an_q         <= '0;
            prev_q         <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            shadow_blank_q <= '0;
            shadow_err_q   <= '0;
            mask_q         <= '0;
            bcd_q          <= '0;
            blank_q        <= '0;
            valid_q        <= 1'b0;
            err_q          <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef SEG_SCAN_ERRCNT_EN
            errcnt_q       <= '0;
`endif
        end else begin
            s_seg_q        <= s_seg_d;
            s_an_q         <= s_an_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_err_q   <= shadow_err_d;
            mask_q         <= mask_d;
            bcd_q          <= bcd_d;
            blank_q        <= blank_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
            overrun_q      <= overrun_d;
`ifdef SEG_SCAN_ERRCNT_EN
            errcnt_q       <= errcnt_d;
`endif
        end
    end

    assign bcd_out     = bcd_q;
    assign blank_out   = blank_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;
`ifdef SEG_SCAN_ERRCNT_EN
    assign err_count   = errcnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture; define SEG_SCAN_ERRCNT_EN to also check err_count.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        frame_valid;
    logic        frame_ack;
    logic        frame_err;
    logic        overrun;
`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .bcd_out     (bcd_out),
        .blank_out   (blank_out),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_err   (frame_err),
        .overrun     (overrun)
`ifdef SEG_SCAN_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int unsigned n);
        an_in  = an;
        seg_in = seg;
        step(n);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        show(4'b1110, s0, 8);
        show(4'b1101, s1, 8);
        show(4'b1011, s2, 8);
        show(4'b0111, s3, 8);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack_one();
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; an_in = 4'hF; seg_in = 7'h7F; frame_ack = 1'b0;
        step(3);
        chk("rst_valid",   {31'd0, frame_valid}, 32'd0);
        chk("rst_bcd",     {16'd0, bcd_out},     32'd0);
        chk("rst_blank",   {28'd0, blank_out},   32'd0);
        chk("rst_err",     {31'd0, frame_err},   32'd0);
        chk("rst_overrun", {31'd0, overrun},     32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic frame 1,2,3,4
        show(4'b1110, 7'h79, 8);
        show(4'b1101, 7'h24, 8);
        show(4'b1011, 7'h30, 8);
        chk("partial_no_frame", {31'd0, frame_valid}, 32'd0);
        show(4'b0111, 7'h19, 8);
        chk("f1_valid", {31'd0, frame_valid}, 32'd1);
        chk("f1_bcd",   {16'd0, bcd_out},     32'h4321);
        chk("f1_err",   {31'd0, frame_err},   32'd0);
        chk("f1_blank", {28'd0, blank_out},   32'd0);
        an_in = 4'hF;
        ack_one();
        chk("f1_ack_clear", {31'd0, frame_valid}, 32'd0);
        ack_one();
        chk("ack_idle_ignored", {31'd0, frame_valid}, 32'd0);

        // Digit 0 held one cycle short of stable: not captured
        show(4'b1110, 7'h40, 3);
        show(4'b1101, 7'h79, 8);
        show(4'b1011, 7'h24, 8);
        show(4'b0111, 7'h30, 8);
        show(4'b1111, 7'h7F, 4);
        chk("short_hold_no_frame", {31'd0, frame_valid}, 32'd0);
        show(4'b1110, 7'h40, 8);
        chk("long_hold_valid", {31'd0, frame_valid}, 32'd1);
        chk("long_hold_bcd",   {16'd0, bcd_out},     32'h3210);
        an_in = 4'hF;
        ack_one();

        // Blank and undecodable digits
        scan4(7'h40, 7'h79, 7'h7F, 7'h7E);
        chk("bl_valid", {31'd0, frame_valid}, 32'd1);
        chk("bl_blank", {28'd0, blank_out},   32'b0100);
        chk("bl_err",   {31'd0, frame_err},   32'd1);
        chk("bl_bcd",   {16'd0, bcd_out},     32'h0010);
`ifdef SEG_SCAN_ERRCNT_EN
        chk("bl_errcnt", {24'd0, err_count}, 32'd1);
`endif
        an_in = 4'hF;
        ack_one();

        // Overrun: two frames without ack
        scan4(7'h12, 7'h02, 7'h78, 7'h00);
        chk("ovr_a_bcd", {16'd0, bcd_out}, 32'h8765);
        scan4(7'h10, 7'h40, 7'h79, 7'h24);
        chk("ovr_valid",    {31'd0, frame_valid}, 32'd1);
        chk("ovr_retained", {16'd0, bcd_out},     32'h8765);
        chk("ovr_sticky",   {31'd0, overrun},     32'd1);

        // Ack coinciding with completion: last digit's shadow write at 5th edge, completion at 6th
        show(4'b1110, 7'h78, 8);
        show(4'b1101, 7'h40, 8);
        show(4'b1011, 7'h12, 8);
        show(4'b0111, 7'h79, 5);
        chk("coin_pre_bcd", {16'd0, bcd_out}, 32'h8765);
        ack_one();
        chk("coin_valid", {31'd0, frame_valid}, 32'd1);
        chk("coin_bcd",   {16'd0, bcd_out},     32'h1507);
        step(2);
        chk("coin_hold",    {31'd0, frame_valid}, 32'd1);
        chk("coin_overrun", {31'd0, overrun},     32'd1);
        an_in = 4'hF;
        ack_one();
        chk("coin_ack_clear", {31'd0, frame_valid}, 32'd0);

        // Invalid anode words do not disturb the partial mask
        show(4'b1110, 7'h30, 8);
        show(4'b1101, 7'h19, 8);
        show(4'b0011, 7'h40, 20);
        show(4'b1111, 7'h40, 20);
        chk("idle_no_frame", {31'd0, frame_valid}, 32'd0);
        show(4'b1011, 7'h12, 8);
        show(4'b0111, 7'h02, 8);
        chk("idle_mask_kept", {31'd0, frame_valid}, 32'd1);
        chk("idle_bcd",       {16'd0, bcd_out},     32'h6543);
        an_in = 4'hF;
        ack_one();

        // Reset mid-frame
        show(4'b1110, 7'h10, 8);
        show(4'b1101, 7'h00, 8);
        an_in = 4'hF;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mrst_overrun", {31'd0, overrun},   32'd0);
        chk("mrst_bcd",     {16'd0, bcd_out},   32'd0);
        chk("mrst_valid",   {31'd0, frame_valid}, 32'd0);
        show(4'b1011, 7'h78, 8);
        show(4'b0111, 7'h02, 8);
        show(4'b1111, 7'h7F, 4);
        chk("mrst_no_frame", {31'd0, frame_valid}, 32'd0);
        scan4(7'h10, 7'h00, 7'h78, 7'h02);
        chk("mrst_full_valid", {31'd0, frame_valid}, 32'd1);
        chk("mrst_full_bcd",   {16'd0, bcd_out},     32'h6789);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
